// File: rtl/axis_bypass_arbiter_if.sv
// Upstream and downstream AXI-Stream signals of the bypass arbiter.
interface axis_bypass_arbiter_if #(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned KEEP_W = DATA_WIDTH / 8;

  logic [NUM_IN-1:0]            S_AXIS_TVALID;
  logic [NUM_IN-1:0]            S_AXIS_TREADY;
  logic [NUM_IN*DATA_WIDTH-1:0] S_AXIS_TDATA;
  logic [NUM_IN*KEEP_W-1:0]     S_AXIS_TKEEP;
  logic [NUM_IN-1:0]            S_AXIS_TLAST;

  logic                  M_AXIS_TVALID;
  logic                  M_AXIS_TREADY;
  logic [DATA_WIDTH-1:0] M_AXIS_TDATA;
  logic [KEEP_W-1:0]     M_AXIS_TKEEP;
  logic                  M_AXIS_TLAST;
  logic [7:0]            M_AXIS_TID;

  // Arbiter view: stream slave towards the sources, master towards the datapath.
  modport slave (
    input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST, M_AXIS_TREADY,
    output S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST,
           M_AXIS_TID
  );

  // Environment view: drives the sources and the downstream ready.
  modport master (
    output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST, M_AXIS_TREADY,
    input  S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST,
           M_AXIS_TID
  );
endinterface

// File: rtl/axis_bypass_arbiter.sv
// Packet-granular arbiter sharing the bypass stream datapath between NUM_IN sources.
module axis_bypass_arbiter #(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  axis_bypass_arbiter_if.slave axis,
  input  logic [NUM_IN-1:0]    cfg_enable,
  input  logic                 cfg_prio_mode,
  output logic [NUM_IN-1:0]    sts_grant,
  output logic                 sts_busy,
  output logic [CNT_WIDTH-1:0] sts_pkt_count
);
  localparam int unsigned KEEP_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = $clog2(NUM_IN);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic [0:0]           state_q,     state_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q,       cnt_d;
  logic [NUM_IN-1:0]    grant_q,     grant_d;
  logic                 busy_q,      busy_d;

  logic [NUM_IN-1:0]    req_c;
  logic [IDX_W-1:0]     win_idx_c;
  logic                 found_c;
  logic                 last_hs_c;

  // Pick the winner among enabled requesters (fixed priority or round-robin from rr_ptr).
  always_comb begin
    req_c     = axis.S_AXIS_TVALID & cfg_enable;
    win_idx_c = '0;
    found_c   = 1'b0;
    if (cfg_prio_mode) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (!found_c && req_c[i]) begin
          win_idx_c = IDX_W'(i);
          found_c   = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        if (!found_c && req_c[IDX_W'((32'(rr_ptr_q) + k) % NUM_IN)]) begin
          win_idx_c = IDX_W'((32'(rr_ptr_q) + k) % NUM_IN);
          found_c   = 1'b1;
        end
      end
    end
  end

  // Zero-latency passthrough of the granted source while in XFER; all zero in IDLE.
  always_comb begin
    axis.M_AXIS_TVALID = 1'b0;
    axis.M_AXIS_TDATA  = '0;
    axis.M_AXIS_TKEEP  = '0;
    axis.M_AXIS_TLAST  = 1'b0;
    axis.M_AXIS_TID    = '0;
    axis.S_AXIS_TREADY = '0;
    if (state_q == ST_XFER) begin
      axis.M_AXIS_TID = 8'(grant_idx_q);
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (grant_idx_q == IDX_W'(i)) begin
          axis.M_AXIS_TVALID    = axis.S_AXIS_TVALID[i];
          axis.M_AXIS_TDATA     = axis.S_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
          axis.M_AXIS_TKEEP     = axis.S_AXIS_TKEEP[i*KEEP_W +: KEEP_W];
          axis.M_AXIS_TLAST     = axis.S_AXIS_TLAST[i];
          axis.S_AXIS_TREADY[i] = axis.M_AXIS_TREADY;
        end
      end
    end
  end

  assign last_hs_c = axis.M_AXIS_TVALID & axis.M_AXIS_TREADY & axis.M_AXIS_TLAST;

  // Next-state: grant in IDLE, release and account on the TLAST handshake.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (req_c != '0) begin
          state_d     = ST_XFER;
          grant_idx_d = win_idx_c;
          grant_d     = NUM_IN'(1) << win_idx_c;
          busy_d      = 1'b1;
        end
      end
      ST_XFER: begin
        if (last_hs_c) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          busy_d   = 1'b0;
          rr_ptr_d = (grant_idx_q == IDX_W'(NUM_IN - 1)) ? '0 : grant_idx_q + IDX_W'(1);
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
    end
  end

  assign sts_grant     = grant_q;
  assign sts_busy      = busy_q;
  assign sts_pkt_count = cnt_q;
endmodule
